// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage placed after the single-cycle datapath. A load or
// store seen in IDLE is checked for alignment, formatted onto a word-wide
// valid/ready bus, and held there until the slave answers or the wait budget
// runs out. Stall keeps the PC frozen while the access is in flight; the
// instruction retires on the DONE cycle where ReadData carries the formatted
// load result.
//
// Parameters
//   TIMEOUT        max REQ cycles waiting for bus_ready before aborting (>=1)
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   MemRead        load request
//   MemWrite       store request (wins when both are high)
//   Funct3         size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   ALUResult      byte address
//   WriteData      right-aligned store data
//   ReadData       formatted load data (non-zero only in DONE)
//   Stall          high while an access is outstanding
//   MisalignFault  one-cycle pulse on misaligned/unsupported access
//   BusFault       one-cycle pulse (DONE cycle) after a bus timeout
//   bus_*          word-aligned valid/ready memory bus
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignFault,
    output logic        BusFault,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bfault_q, bfault_d;

    // ------------------------------------------------------------------
    // Request decode (meaningful only while IDLE)
    // ------------------------------------------------------------------
    logic        req;
    logic        is_store;
    logic        legal;
    logic [1:0]  off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    assign req      = MemRead | MemWrite;
    assign is_store = MemWrite;
    assign off      = ALUResult[1:0];

    always_comb begin
        legal     = 1'b0;
        req_be    = 4'b0000;
        req_wdata = 32'h0;

        case (Funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~off[0];
            3'b010:         legal = (off == 2'b00);
            default:        legal = 1'b0;
        endcase
        // Stores have no signed/unsigned variants
        if (is_store && Funct3[2])
            legal = 1'b0;

        // Lane enables follow the access size for both loads and stores
        case (Funct3[1:0])
            2'b00:   req_be = 4'b0001 << off;
            2'b01:   req_be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   req_be = 4'b1111;
            default: req_be = 4'b0000;
        endcase

        // Replicate store data on every lane so the slave just uses be
        if (is_store) begin
            case (Funct3[1:0])
                2'b00:   req_wdata = {4{WriteData[7:0]}};
                2'b01:   req_wdata = {2{WriteData[15:0]}};
                default: req_wdata = WriteData;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath register inputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        f3_d     = f3_q;
        rdata_d  = rdata_q;
        bfault_d = bfault_q;

        case (state_q)
            IDLE: begin
                if (req && legal) begin
                    state_d  = REQ;
                    cnt_d    = '0;
                    addr_d   = ALUResult;
                    wdata_d  = req_wdata;
                    be_d     = req_be;
                    we_d     = is_store;
                    f3_d     = Funct3;
                    rdata_d  = 32'h0;
                    bfault_d = 1'b0;
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_d = DONE;
                    rdata_d = we_q ? 32'h0 : bus_rdata;
                end else if (cnt_q == CNT_MAX) begin
                    // Give up: abort with zero data and flag it in DONE
                    state_d  = DONE;
                    rdata_d  = 32'h0;
                    bfault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Always return to IDLE; a request still held high here
                // belongs to the retiring instruction and is not reissued.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'b0000;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            rdata_q  <= 32'h0;
            bfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            rdata_q  <= rdata_d;
            bfault_q <= bfault_d;
        end
    end

    // ------------------------------------------------------------------
    // Load data formatting (DONE only)
    // ------------------------------------------------------------------
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] fmt;

    assign sel_b = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    assign sel_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        fmt = 32'h0;
        if (!we_q) begin
            case (f3_q)
                3'b000:  fmt = {{24{sel_b[7]}}, sel_b};
                3'b100:  fmt = {24'h0, sel_b};
                3'b001:  fmt = {{16{sel_h[15]}}, sel_h};
                3'b101:  fmt = {16'h0, sel_h};
                3'b010:  fmt = rdata_q;
                default: fmt = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_idle, in_req, in_done;

    assign in_idle = (state_q == IDLE);
    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    // IDLE-phase outputs are combinational on the request inputs, so they
    // are qualified with reset to keep every output low while it is held.
    assign Stall         = in_req | (in_idle & reset & req & legal);
    assign MisalignFault = in_idle & reset & req & ~legal;
    assign BusFault      = in_done & bfault_q;
    assign ReadData      = in_done ? fmt : 32'h0;

    assign bus_valid = in_req;
    assign bus_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wdata = in_req ? wdata_q : 32'h0;
    assign bus_be    = in_req ? be_q : 4'b0000;
    assign bus_we    = in_req & we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit built with TIMEOUT=4. Inputs change 1ns
// after the rising edge; outputs are sampled 2ns later, well clear of the edge.
// Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MisalignFault, BusFault;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we, bus_valid, bus_ready;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Funct3       (Funct3),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .MisalignFault(MisalignFault),
        .BusFault     (BusFault),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_we       (bus_we),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One legal access: IDLE launch, `waits` REQ cycles without ready, one
    // REQ cycle with ready, then DONE where ReadData is checked.
    task automatic run_acc(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rdat, input logic [31:0] e_addr,
                           input logic [3:0] e_be, input logic [31:0] e_wdata,
                           input logic e_we, input logic [31:0] e_rd);
        int stall_cycles;
        stall_cycles = 0;
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        #2;
        chk({tag, ".idle_stall"}, {31'h0, Stall}, 32'd1);
        chk({tag, ".idle_valid"}, {31'h0, bus_valid}, 32'd0);
        if (Stall) stall_cycles++;
        for (int i = 0; i <= waits; i++) begin
            cyc();
            if (i == waits) begin
                bus_ready = 1'b1;
                bus_rdata = rdat;
            end
            #2;
            if (Stall) stall_cycles++;
            chk({tag, ".valid"}, {31'h0, bus_valid}, 32'd1);
            chk({tag, ".addr"},  bus_addr, e_addr);
            chk({tag, ".be"},    {28'h0, bus_be}, {28'h0, e_be});
            chk({tag, ".wdata"}, bus_wdata, e_wdata);
            chk({tag, ".we"},    {31'h0, bus_we}, {31'h0, e_we});
            chk({tag, ".req_rd"}, ReadData, 32'h0);
        end
        cyc();
        bus_ready = 1'b0;
        bus_rdata = 32'h5A5A5A5A;
        #2;
        if (Stall) stall_cycles++;
        chk({tag, ".stall_cycles"}, stall_cycles, waits + 2);
        chk({tag, ".done_valid"}, {31'h0, bus_valid}, 32'd0);
        chk({tag, ".done_bfault"}, {31'h0, BusFault}, 32'd0);
        chk({tag, ".ReadData"}, ReadData, e_rd);
        MemRead = 1'b0; MemWrite = 1'b0;
        cyc();
        #2;
        chk({tag, ".idle_rd"}, ReadData, 32'h0);
        chk({tag, ".idle_stall2"}, {31'h0, Stall}, 32'd0);
    endtask

    // Illegal request: fault pulse for one cycle, never reaches the bus.
    task automatic run_bad(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = 32'h1234_5678;
        bus_ready = 1'b0;
        #2;
        chk({tag, ".misalign"}, {31'h0, MisalignFault}, 32'd1);
        chk({tag, ".stall"}, {31'h0, Stall}, 32'd0);
        chk({tag, ".valid"}, {31'h0, bus_valid}, 32'd0);
        cyc();
        MemRead = 1'b0; MemWrite = 1'b0;
        #2;
        chk({tag, ".misalign_off"}, {31'h0, MisalignFault}, 32'd0);
        chk({tag, ".valid2"}, {31'h0, bus_valid}, 32'd0);
        cyc();
    endtask

    initial begin
        reset = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'h0; WriteData = 32'h0;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        #2;
        chk("rst.valid", {31'h0, bus_valid}, 32'd0);
        chk("rst.stall", {31'h0, Stall}, 32'd0);
        chk("rst.rd", ReadData, 32'h0);
        chk("rst.addr", bus_addr, 32'h0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        #2;
        chk("idle.nop_stall", {31'h0, Stall}, 32'd0);
        chk("idle.nop_valid", {31'h0, bus_valid}, 32'd0);
        cyc();

        //       tag    rd    wr    f3      addr          wdata          w  rdata          e_addr        be       e_wdata        we    e_rd
        run_acc("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         0, 32'hDEADBEEF, 32'h0000_0100, 4'b1111, 32'h0,         1'b0, 32'hDEADBEEF);
        run_acc("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,         0, 32'h80FF_0000, 32'h0000_0200, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80);
        run_acc("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,         0, 32'h80FF_0000, 32'h0000_0200, 4'b1000, 32'h0,        1'b0, 32'h0000_0080);
        run_acc("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         0, 32'h80FF_0000, 32'h0000_0200, 4'b1100, 32'h0,        1'b0, 32'hFFFF_80FF);
        run_acc("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         1, 32'h80FF_0000, 32'h0000_0200, 4'b1100, 32'h0,        1'b0, 32'h0000_80FF);
        run_acc("lb1",  1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0,         2, 32'h0000_7F00, 32'h0000_0000, 4'b0010, 32'h0,        1'b0, 32'h0000_007F);
        run_acc("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 3, 32'hFFFF_FFFF, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0);
        run_acc("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h1234_56EF, 0, 32'h0,         32'h0000_0020, 4'b0010, 32'hEFEF_EFEF, 1'b1, 32'h0);
        run_acc("sw_rw",1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h1111_1111, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0);

        run_bad("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0101);
        run_bad("f3_011",  1'b1, 1'b0, 3'b011, 32'h0000_0100);
        run_bad("lh_odd",  1'b1, 1'b0, 3'b001, 32'h0000_0203);
        run_bad("sbu_st",  1'b0, 1'b1, 3'b100, 32'h0000_0100);

        // Timeout: TIMEOUT=4 gives four REQ cycles then a faulted DONE
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
        bus_ready = 1'b0; bus_rdata = 32'h1111_1111;
        #2;
        chk("to.idle_stall", {31'h0, Stall}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #2;
            chk("to.valid", {31'h0, bus_valid}, 32'd1);
            chk("to.bfault_req", {31'h0, BusFault}, 32'd0);
        end
        cyc();
        #2;
        chk("to.done_valid", {31'h0, bus_valid}, 32'd0);
        chk("to.bfault", {31'h0, BusFault}, 32'd1);
        chk("to.rd", ReadData, 32'h0);
        chk("to.stall", {31'h0, Stall}, 32'd0);
        MemRead = 1'b0;
        cyc();
        #2;
        chk("to.bfault_off", {31'h0, BusFault}, 32'd0);
        chk("to.idle_valid", {31'h0, bus_valid}, 32'd0);
        cyc();

        // Reset while REQ is outstanding
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h500; bus_ready = 1'b0;
        cyc();
        #2;
        chk("mrst.pre_valid", {31'h0, bus_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mrst.valid", {31'h0, bus_valid}, 32'd0);
        chk("mrst.stall", {31'h0, Stall}, 32'd0);
        chk("mrst.faults", {30'h0, MisalignFault, BusFault}, 32'd0);
        MemRead = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        #2;
        chk("mrst.idle_valid", {31'h0, bus_valid}, 32'd0);
        chk("mrst.idle_stall", {31'h0, Stall}, 32'd0);
        cyc();
        run_acc("post_rst_lw", 1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 0, 32'h0BAD_CAFE,
                32'h0000_0600, 4'b1111, 32'h0, 1'b0, 32'h0BAD_CAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
